// File: rtl/mips_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mips_muldiv_seq
//  Description : Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and the HI/LO
//                register pair. Iterative shift-add multiply and restoring
//                divide, one step per cycle over DATA_WIDTH cycles, with a
//                pipeline stall request for dependent MFHI/MFLO or a new
//                mul/div arriving while an operation is in flight.
//  Optional    : `define MIPS_MDU_EARLY_OUT_EN lets PREP detect a zero operand
//                and skip the iteration phase (3-cycle latency, same results).
//  Ports       : clk, rst_n        clock, asynchronous active-low reset
//                start, op         request valid and opcode
//                                  (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//                rs_val, rt_val    operand A / operand B
//                mf_req            MFHI/MFLO in decode this cycle
//                flush             abort the operation in flight
//                busy, stall_req   status toward the pipeline
//                done              one-cycle pulse: HI/LO written this cycle
//                hi_out, lo_out    HI / LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  input  logic                  mf_req,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_load = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

  state_t                r_state;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_rs;       // raw operand A (needed for divide-by-zero HI)
  logic [DATA_WIDTH-1:0] r_rt;       // raw operand B
  logic [DATA_WIDTH-1:0] r_acc;      // product upper half / partial remainder
  logic [DATA_WIDTH-1:0] r_lo;       // multiplier -> product lower half; dividend -> quotient
  logic [DATA_WIDTH-1:0] r_b;        // multiplicand magnitude or divisor magnitude
  logic                  r_sign_q;
  logic                  r_sign_r;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_hi_out;
  logic [DATA_WIDTH-1:0] r_lo_out;

  logic                    w_is_div;
  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_a_mag;
  logic [DATA_WIDTH-1:0]   w_b_mag;
  logic                    w_zero_op;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_rem_sh;
  logic                    w_ge;
  logic [DATA_WIDTH-1:0]   w_diff;
  logic [2*DATA_WIDTH-1:0] w_prod_fix;
  logic [DATA_WIDTH-1:0]   w_quo_fix;
  logic [DATA_WIDTH-1:0]   w_rem_fix;
  logic                    w_busy;

  always_comb begin
    w_is_div   = r_op[1];
    // op[0]=0 selects the signed variants
    w_a_neg    = ~r_op[0] & r_rs[DATA_WIDTH-1];
    w_b_neg    = ~r_op[0] & r_rt[DATA_WIDTH-1];
    w_a_mag    = w_a_neg ? (~r_rs + 1'b1) : r_rs;
    w_b_mag    = w_b_neg ? (~r_rt + 1'b1) : r_rt;
    w_zero_op  = (r_rs == '0) | (r_rt == '0);
    // multiply step: conditional add of the multiplicand into the upper half
    w_sum      = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
    // divide step: shift next dividend bit into the partial remainder
    w_rem_sh   = {r_acc, r_lo[DATA_WIDTH-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_b});
    // when w_ge holds the difference is below the divisor, so W bits suffice
    w_diff     = w_rem_sh[DATA_WIDTH-1:0] - r_b;
    w_prod_fix = r_sign_q ? (~{r_acc, r_lo} + 1'b1) : {r_acc, r_lo};
    w_quo_fix  = r_sign_q ? (~r_lo + 1'b1) : r_lo;
    w_rem_fix  = r_sign_r ? (~r_acc + 1'b1) : r_acc;
    w_busy     = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_hi_out <= '0;
      r_lo_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // flush beats a simultaneous start
          if (start && !flush) begin
            r_op    <= op;
            r_rs    <= rs_val;
            r_rt    <= rt_val;
            r_state <= ST_PREP;
          end
        end

        ST_PREP: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_sign_q <= w_a_neg ^ w_b_neg;
            r_sign_r <= w_a_neg;
            r_cnt    <= c_cnt_load;
            r_acc    <= '0;
            r_b      <= w_is_div ? w_b_mag : w_a_mag;
            r_lo     <= w_is_div ? w_a_mag : w_b_mag;
            r_state  <= ST_RUN;
`ifdef MIPS_MDU_EARLY_OUT_EN
            // A zero operand makes every partial result zero; FIX then
            // produces the final value (including divide-by-zero) directly.
            if (w_zero_op) begin
              r_lo    <= '0;
              r_state <= ST_FIX;
            end
`endif
          end
        end

        ST_RUN: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_is_div) begin
              r_acc <= w_ge ? w_diff : w_rem_sh[DATA_WIDTH-1:0];
              r_lo  <= {r_lo[DATA_WIDTH-2:0], w_ge};
            end else begin
              r_acc <= w_sum[DATA_WIDTH:1];
              r_lo  <= {w_sum[0], r_lo[DATA_WIDTH-1:1]};
            end
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == c_cnt_one) begin
              r_state <= ST_FIX;
            end
          end
        end

        ST_FIX: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            if (!w_is_div) begin
              {r_acc, r_lo} <= w_prod_fix;
            end else if (r_rt == '0) begin
              // divide by zero: all-ones quotient, raw dividend as remainder
              r_acc <= r_rs;
              r_lo  <= '1;
            end else begin
              r_acc <= w_rem_fix;
              r_lo  <= w_quo_fix;
            end
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // HI/LO are written at the end of the done cycle; a flush that
          // lands in this cycle still suppresses the write.
          if (!flush) begin
            r_hi_out <= r_acc;
            r_lo_out <= r_lo;
          end
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Unused outside the early-out build; keeps the decode in one place.
  logic w_unused;
  assign w_unused = w_zero_op;

  assign busy      = w_busy;
  // A dependent MFHI/MFLO in the DONE cycle reads the new value next cycle.
  assign stall_req = w_busy & (start | (mf_req & (r_state != ST_DONE)));
  assign done      = r_done;
  assign hi_out    = r_hi_out;
  assign lo_out    = r_lo_out;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_muldiv_seq
//  Description : Self-checking bench for mips_muldiv_seq: table of directed
//                mul/div vectors plus hand-written stall, flush and reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_muldiv_seq;

  localparam int W = 32;
  localparam logic [1:0] c_mult  = 2'b00;
  localparam logic [1:0] c_multu = 2'b01;
  localparam logic [1:0] c_div   = 2'b10;
  localparam logic [1:0] c_divu  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         mf_req = 1'b0;
  logic         flush = 1'b0;
  logic         busy, stall_req, done;
  logic [W-1:0] hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;

  mips_muldiv_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request in one cycle; it is taken at the following rising edge.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle count (request cycle = 0) at which done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      if (!found) begin
        @(negedge clk);
        if (done) begin
          lat = c;
          found = 1'b1;
        end
      end
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MIPS_MDU_EARLY_OUT_EN
    if (a == '0 || b == '0) return 3;
`endif
    return W + 3;
  endfunction

  initial begin
    int lat;
    int n_done;

    vecs[0]  = '{c_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{c_mult,  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[2]  = '{c_div,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{c_divu,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{c_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{c_multu, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
    vecs[6]  = '{c_div,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{c_divu,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[8]  = '{c_mult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{c_div,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{c_multu, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[11] = '{c_divu,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[12] = '{c_div,   32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
    vecs[13] = '{c_mult,  32'd12345,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_hi",    hi_out,             32'd0);
    chk("rst_lo",    lo_out,             32'd0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].rs, vecs[i].rt));
      @(negedge clk);
      chk($sformatf("v%0d_hi", i), hi_out, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo_out, vecs[i].lo);
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // ---------------- mf_req from RUN cycle 5 until DONE ----------------
    start_op(c_multu, 32'd3, 32'd4);
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (c == 6) mf_req = 1'b1;
      #1;
      if (c >= 6) chk($sformatf("mf_stall_c%0d", c), {31'd0, stall_req}, (c < W + 3) ? 32'd1 : 32'd0);
      if (c == W + 3) chk("mf_done", {31'd0, done}, 32'd1);
    end
    mf_req = 1'b0;
    @(negedge clk);
    chk("mf_hi", hi_out, 32'd0);
    chk("mf_lo", lo_out, 32'd12);

    // ---------------- second start held during RUN ----------------
    start_op(c_multu, 32'd3, 32'd4);
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1; op = c_multu; rs_val = 32'd5; rt_val = 32'd6;
      end
      #1;
      if (c >= 10) chk($sformatf("hold_stall_c%0d", c), {31'd0, stall_req}, 32'd1);
      if (c == W + 3) chk("hold_done_a", {31'd0, done}, 32'd1);
    end
    @(negedge clk);
    #1;
    chk("hold_idle_busy",  {31'd0, busy},      32'd0);
    chk("hold_idle_stall", {31'd0, stall_req}, 32'd0);
    chk("hold_a_lo", lo_out, 32'd12);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("hold_b_latency", lat, W + 3);
    @(negedge clk);
    chk("hold_b_hi", hi_out, 32'd0);
    chk("hold_b_lo", lo_out, 32'd30);

    // ---------------- flush + start together in IDLE ----------------
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = c_multu; rs_val = 32'd2; rt_val = 32'd2;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flush_start_busy", {31'd0, busy}, 32'd0);

    // ---------------- flush at RUN cycle 10 ----------------
    start_op(c_divu, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("flush_no_done", n_done, 32'd0);
    chk("flush_hi_kept", hi_out, 32'd0);
    chk("flush_lo_kept", lo_out, 32'd30);

    // ---------------- reset at RUN cycle 10 ----------------
    start_op(c_multu, 32'd9, 32'd9);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("arst_no_done", n_done, 32'd0);
    chk("arst_lo_after", lo_out, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
